// File: rtl/bus_cycle_ctrl_if.sv
// Core-request and external-bus signals of the 8008-style bus cycle controller.
interface bus_cycle_ctrl_if #(
   parameter int AW = 14,
   parameter int DW = 8
);
   logic          req;
   logic [1:0]    cyc_type;
   logic [AW-1:0] addr;
   logic [DW-1:0] wdata;
   logic          long_cyc;
   logic          ready;
   logic [DW-1:0] bus_in;
   logic [DW-1:0] bus_out;
   logic          bus_oe;
   logic [2:0]    state_code;
   logic          busy;
   logic [DW-1:0] rdata;
   logic          done;
   logic          err;

   modport master (
      output req, cyc_type, addr, wdata, long_cyc, ready, bus_in,
      input  bus_out, bus_oe, state_code, busy, rdata, done, err
   );

   modport slave (
      input  req, cyc_type, addr, wdata, long_cyc, ready, bus_in,
      output bus_out, bus_oe, state_code, busy, rdata, done, err
   );
endinterface

// File: rtl/bus_cycle_ctrl.sv
// T-state sequencer multiplexing one 8008-style core transfer onto the shared 8-bit bus.
// Define BUS_WAIT_TIMEOUT_EN to build the WAIT timeout abort and sticky err flag.
module bus_cycle_ctrl #(
   parameter int AW      = 14,
   parameter int DW      = 8,
   parameter int TIMEOUT = 16
) (
   input logic             clock,
   input logic             reset_L,
   bus_cycle_ctrl_if.slave bus
);

   // State values are the T-state codes, so state_code comes straight off the register.
   typedef enum logic [2:0] {
      S_IDLE = 3'b011,
      S_T1   = 3'b010,
      S_T2   = 3'b100,
      S_WAIT = 3'b000,
      S_T3   = 3'b001,
      S_T4   = 3'b111,
      S_T5   = 3'b101
   } state_t;

   state_t        state, state_nxt;
   logic [1:0]    type_q;
   logic [AW-1:0] addr_q;
   logic [DW-1:0] wdata_q;
   logic          long_q;
   logic [DW-1:0] bus_out_q, bus_out_nxt;
   logic          bus_oe_q, bus_oe_nxt;
   logic [DW-1:0] rdata_q;
   logic          done_q, done_nxt;
   logic          load, capture, is_write;

   if (AW != 14 || DW != 8 || TIMEOUT < 1) begin : g_bad_cfg
      $error("bus_cycle_ctrl: AW must be 14, DW must be 8 and TIMEOUT at least 1");
   end

`ifdef BUS_WAIT_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT - 1);

   logic [CW-1:0] wait_cnt;
   logic          err_q;
   logic          abort;
`endif

   assign is_write = (type_q == 2'b11);

   always_ff @(posedge clock or negedge reset_L) begin
      if (!reset_L) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      load      = 1'b0;
      capture   = 1'b0;
      done_nxt  = 1'b0;
`ifdef BUS_WAIT_TIMEOUT_EN
      abort     = 1'b0;
`endif
      case (state)
         S_IDLE: begin
            if (bus.req) begin
               state_nxt = S_T1;
               load      = 1'b1;
            end
         end
         S_T1: state_nxt = S_T2;
         S_T2: state_nxt = bus.ready ? S_T3 : S_WAIT;
         S_WAIT: begin
            if (bus.ready) begin
               state_nxt = S_T3;
`ifdef BUS_WAIT_TIMEOUT_EN
            end else if (wait_cnt == WAIT_LAST) begin
               state_nxt = S_IDLE;
               abort     = 1'b1;
               done_nxt  = 1'b1;
`endif
            end
         end
         S_T3: begin
            capture = !is_write;
            if (long_q) begin
               state_nxt = S_T4;
            end else begin
               done_nxt = 1'b1;
               if (bus.req) begin
                  state_nxt = S_T1;
                  load      = 1'b1;
               end else begin
                  state_nxt = S_IDLE;
               end
            end
         end
         S_T4: state_nxt = S_T5;
         S_T5: begin
            done_nxt = 1'b1;
            if (bus.req) begin
               state_nxt = S_T1;
               load      = 1'b1;
            end else begin
               state_nxt = S_IDLE;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // Bus drive is decoded from the next state so bus_out/bus_oe leave a flop.
   // T1 is only ever entered on a load, so the low address comes from the live input.
   always_comb begin
      bus_oe_nxt  = 1'b0;
      bus_out_nxt = '0;
      case (state_nxt)
         S_T1: begin
            bus_oe_nxt  = 1'b1;
            bus_out_nxt = bus.addr[DW-1:0];
         end
         S_T2: begin
            bus_oe_nxt  = 1'b1;
            bus_out_nxt = {type_q, addr_q[AW-1:DW]};
         end
         S_T3: begin
            if (is_write) begin
               bus_oe_nxt  = 1'b1;
               bus_out_nxt = wdata_q;
            end
         end
         default: begin
            bus_oe_nxt  = 1'b0;
            bus_out_nxt = '0;
         end
      endcase
   end

   always_ff @(posedge clock or negedge reset_L) begin
      if (!reset_L) begin
         type_q    <= 2'b00;
         addr_q    <= '0;
         wdata_q   <= '0;
         long_q    <= 1'b0;
         bus_out_q <= '0;
         bus_oe_q  <= 1'b0;
         rdata_q   <= '0;
         done_q    <= 1'b0;
      end else begin
         bus_out_q <= bus_out_nxt;
         bus_oe_q  <= bus_oe_nxt;
         done_q    <= done_nxt;
         if (load) begin
            type_q  <= bus.cyc_type;
            addr_q  <= bus.addr;
            wdata_q <= bus.wdata;
            long_q  <= bus.long_cyc;
         end
         if (capture) begin
            rdata_q <= bus.bus_in;
         end
      end
   end

`ifdef BUS_WAIT_TIMEOUT_EN
   // Counter holds at zero outside WAIT, so it restarts on every WAIT entry.
   always_ff @(posedge clock or negedge reset_L) begin
      if (!reset_L) begin
         wait_cnt <= '0;
         err_q    <= 1'b0;
      end else begin
         if (state != S_WAIT) begin
            wait_cnt <= '0;
         end else begin
            wait_cnt <= wait_cnt + CW'(1);
         end
         if (abort) begin
            err_q <= 1'b1;
         end
      end
   end

   assign bus.err = err_q;
`else
   assign bus.err = 1'b0;
`endif

   assign bus.bus_out    = bus_out_q;
   assign bus.bus_oe     = bus_oe_q;
   assign bus.state_code = state;
   assign bus.busy       = (state != S_IDLE);
   assign bus.rdata      = rdata_q;
   assign bus.done       = done_q;

endmodule

// File: tb/tb_bus_cycle_ctrl.sv
// Scoreboard bench for bus_cycle_ctrl: transaction-level model pushes expected traces,
// a monitor collects the per-cycle bus trace and checks it on every done pulse.
module tb_bus_cycle_ctrl;

   localparam int TIMEOUT = 16;

   typedef struct packed {
      logic [13:0] addr;
      logic [1:0]  typ;
      logic [7:0]  wdata;
      logic        lng;
      logic [4:0]  nw;
      logic        abort;
      logic [7:0]  bin;
   } txn_t;

   // Each cycle entry is {state_code, bus_oe, bus_out}.
   typedef struct packed {
      logic [31:0][11:0] cyc;
      logic [5:0]        len;
      logic [7:0]        rdata;
      logic              err;
      logic [15:0]       id;
   } exp_t;

   logic clock;
   logic reset_L;

   bus_cycle_ctrl_if #(.AW(14), .DW(8)) bus ();

   bus_cycle_ctrl #(.AW(14), .DW(8), .TIMEOUT(TIMEOUT)) dut (
      .clock   (clock),
      .reset_L (reset_L),
      .bus     (bus)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   int          n_pass = 0;
   int          n_chk  = 0;
   exp_t        exp_q[$];
   txn_t        grp[$];
   logic [7:0]  mdl_rdata = 8'h00;
   logic        mdl_err   = 1'b0;
   int          xid       = 0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req_v);
      n_chk++;
      if (act !== req_v) $display("FAIL %s: got %0h expected %0h", nm, act, req_v);
      else n_pass++;
   endtask

   function automatic txn_t mk(input logic [13:0] a, input logic [1:0] ty, input logic [7:0] wd,
                               input logic lg, input int nw, input logic [7:0] bi);
      txn_t t;
      t.addr = a; t.typ = ty; t.wdata = wd; t.lng = lg;
      t.nw = 5'(nw); t.abort = 1'b0; t.bin = bi;
      return t;
   endfunction

   // Reference model: the bus trace a transfer should produce, from the T-state rules.
   task automatic push_exp(input txn_t t);
      exp_t e;
      int   n;
      int   nwait;
      logic wr;
      e = '0;
      e.cyc[0] = {3'b010, 1'b1, t.addr[7:0]};
      e.cyc[1] = {3'b100, 1'b1, t.typ, t.addr[13:8]};
      n = 2;
      nwait = t.abort ? TIMEOUT : int'(t.nw);
      for (int i = 0; i < nwait; i++) begin
         e.cyc[n] = {3'b000, 1'b0, 8'h00};
         n++;
      end
      if (t.abort) begin
         mdl_err = 1'b1;
      end else begin
         wr = (t.typ == 2'b11);
         e.cyc[n] = {3'b001, wr, wr ? t.wdata : 8'h00};
         n++;
         if (!wr) mdl_rdata = t.bin;
         if (t.lng) begin
            e.cyc[n] = {3'b111, 1'b0, 8'h00};
            e.cyc[n+1] = {3'b101, 1'b0, 8'h00};
            n += 2;
         end
      end
      e.len = 6'(n);
      e.rdata = mdl_rdata;
      e.err = mdl_err;
      e.id = 16'(xid);
      xid++;
      exp_q.push_back(e);
   endtask

   // Monitor: collect busy cycles; on done, pop and compare the finished transfer.
   initial begin
      logic [31:0][11:0] cur;
      int   cur_len;
      exp_t e;
      cur_len = 0;
      cur = '0;
      forever begin
         @(negedge clock);
         if (!reset_L) begin
            cur_len = 0;
            continue;
         end
         if (bus.done) begin
            check("done_has_expected", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
               e = exp_q.pop_front();
               check($sformatf("x%0d_len", e.id), 32'(cur_len), 32'(e.len));
               for (int i = 0; i < int'(e.len) && i < cur_len && i < 32; i++)
                  check($sformatf("x%0d_cyc%0d", e.id, i), 32'(cur[i]), 32'(e.cyc[i]));
               check($sformatf("x%0d_rdata", e.id), 32'(bus.rdata), 32'(e.rdata));
               check($sformatf("x%0d_err", e.id), 32'(bus.err), 32'(e.err));
            end
            cur_len = 0;
         end
         if (bus.busy) begin
            if (cur_len < 32) cur[cur_len] = {bus.state_code, bus.bus_oe, bus.bus_out};
            cur_len++;
         end
      end
   end

   task automatic junk();
      bus.req      = 1'($urandom);
      bus.addr     = 14'($urandom);
      bus.cyc_type = 2'($urandom);
      bus.wdata    = 8'($urandom);
      bus.long_cyc = 1'($urandom);
      bus.ready    = 1'($urandom);
      bus.bus_in   = 8'($urandom);
   endtask

   task automatic drive_fields(input txn_t t);
      bus.req      = 1'b1;
      bus.addr     = t.addr;
      bus.cyc_type = t.typ;
      bus.wdata    = t.wdata;
      bus.long_cyc = t.lng;
   endtask

   // Starts at the negedge where t is presented; ends at the negedge of its final T-state.
   task automatic xfer(input txn_t t, input bit chain, input txn_t nxt);
      int nwait;
      @(negedge clock);
      check("t1_entry", 32'(bus.state_code), 32'h2);
      junk();
      @(negedge clock);
      junk();
      bus.ready = (t.nw == 5'd0) && !t.abort;
      nwait = t.abort ? TIMEOUT : int'(t.nw);
      for (int w = 1; w <= nwait; w++) begin
         @(negedge clock);
         junk();
         bus.ready = !t.abort && (w == int'(t.nw));
      end
      if (t.abort) begin
         bus.req = 1'b0;
         return;
      end
      @(negedge clock);
      junk();
      bus.bus_in = t.bin;
      if (t.lng) begin
         if (chain) drive_fields(nxt);
         @(negedge clock);
         if (chain) begin bus.ready = 1'($urandom); bus.bus_in = 8'($urandom); end
         else junk();
         @(negedge clock);
         if (!chain) junk();
      end
      if (chain) begin
         drive_fields(nxt);
         push_exp(nxt);
      end else begin
         bus.req = 1'b0;
      end
   endtask

   task automatic run_grp();
      drive_fields(grp[0]);
      push_exp(grp[0]);
      for (int i = 0; i < grp.size(); i++) begin
         if (i + 1 < grp.size()) xfer(grp[i], 1'b1, grp[i+1]);
         else xfer(grp[i], 1'b0, grp[i]);
      end
      @(negedge clock);
      bus.req = 1'b0;
      grp.delete();
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_code"}, 32'(bus.state_code), 32'h3);
      check({tag, "_oe"}, 32'(bus.bus_oe), 32'd0);
      check({tag, "_out"}, 32'(bus.bus_out), 32'd0);
      check({tag, "_busy"}, 32'(bus.busy), 32'd0);
      check({tag, "_done"}, 32'(bus.done), 32'd0);
      check({tag, "_rdata"}, 32'(bus.rdata), 32'd0);
      check({tag, "_err"}, 32'(bus.err), 32'd0);
   endtask

   task automatic mid_wait_reset();
      txn_t t;
      t = mk(14'h1ABC, 2'b10, 8'h00, 1'b0, 5, 8'h77);
      drive_fields(t);
      push_exp(t);
      @(negedge clock); junk(); bus.req = 1'b0;
      @(negedge clock); bus.ready = 1'b0;
      @(negedge clock); bus.ready = 1'b0;
      @(negedge clock);
      check("pre_reset_wait", 32'(bus.state_code), 32'h0);
      #2 reset_L = 1'b0;
      #1 check_reset_outputs("async_reset");
      void'(exp_q.pop_back());
      mdl_rdata = 8'h00;
      mdl_err = 1'b0;
      bus.req = 1'b0;
      @(negedge clock);
      #2 reset_L = 1'b1;
      @(negedge clock);
      check("post_reset_idle", 32'(bus.state_code), 32'h3);
   endtask

   initial begin
      txn_t t;
      reset_L = 1'b0;
      bus.req = 1'b1; bus.addr = '0; bus.cyc_type = 2'b00; bus.wdata = '0;
      bus.long_cyc = 1'b0; bus.ready = 1'b1; bus.bus_in = '0;
      repeat (2) @(negedge clock);
      check_reset_outputs("reset");
      reset_L = 1'b1;
      bus.req = 1'b0;
      @(negedge clock);

      grp.push_back(mk(14'h2A5C, 2'b10, 8'h00, 1'b0, 0, 8'h9E)); run_grp();
      grp.push_back(mk(14'h0013, 2'b11, 8'hC3, 1'b0, 0, 8'h55)); run_grp();
      grp.push_back(mk(14'h3F01, 2'b00, 8'h00, 1'b0, 4, 8'h21)); run_grp();
      grp.push_back(mk(14'h0F0F, 2'b01, 8'h00, 1'b0, 1, 8'h6D)); run_grp();
      for (int i = 0; i < 3; i++)
         grp.push_back(mk(14'(14'h1100 + i), 2'(i), 8'(8'hA0 + i), 1'b1, 0, 8'(8'h40 + i)));
      run_grp();

      for (int g = 0; g < 14; g++) begin
         int n;
         n = int'($urandom_range(1, 3));
         for (int i = 0; i < n; i++)
            grp.push_back(mk(14'($urandom), 2'($urandom), 8'($urandom), 1'($urandom),
                             ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 5)) : 0,
                             8'($urandom)));
         run_grp();
         repeat ($urandom_range(0, 2)) @(negedge clock);
      end

      mid_wait_reset();
      grp.push_back(mk(14'h0A0A, 2'b10, 8'h00, 1'b0, 0, 8'h3C)); run_grp();

`ifdef BUS_WAIT_TIMEOUT_EN
      grp.push_back(mk(14'h2222, 2'b00, 8'h00, 1'b0, TIMEOUT, 8'hE7)); run_grp();
      t = mk(14'h3333, 2'b10, 8'h00, 1'b0, 0, 8'h11);
      t.abort = 1'b1;
      grp.push_back(t); run_grp();
      @(negedge clock);
      check("err_sticky", 32'(bus.err), 32'd1);
      grp.push_back(mk(14'h0444, 2'b01, 8'h00, 1'b0, 2, 8'h5A)); run_grp();
      mid_wait_reset();
`endif

      for (int i = 0; i < 50 && exp_q.size() > 0; i++) @(negedge clock);
      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
